// File: rtl/alu_arb.sv
// ---------------------------------------------------------------------------
// alu_arb -- two-requester round-robin front end for one shared combinational ALU.
//
// A request is accepted in IDLE. The winner's op/a/b are latched on that edge.
// In EXEC the latched operands drive the ALU. The ALU result is captured into
// the winner's result/zero registers. DONE then raises that requester's done
// for one cycle. The FSM returns to IDLE after DONE.
//
// Parameters
//   DW   operand / result width
//   OPW  ALUOp width
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   req0/req1              operation requests (sampled in IDLE only)
//   op0/op1, a0/a1, b0/b1  ALUOp and operands per requester
//   done0/done1            one-cycle completion pulse per requester
//   res0/res1, zero0/zero1 result and zero-flag registers per requester
//   alu_a, alu_b, alu_op   drive the shared ALU (zero / NOP when not in EXEC)
//   alu_c, alu_zero        combinational ALU outputs
//   busy                   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arb #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           req0,
    input  logic           req1,
    input  logic [OPW-1:0] op0,
    input  logic [OPW-1:0] op1,
    input  logic [DW-1:0]  a0,
    input  logic [DW-1:0]  a1,
    input  logic [DW-1:0]  b0,
    input  logic [DW-1:0]  b1,
    output logic           done0,
    output logic           done1,
    output logic [DW-1:0]  res0,
    output logic [DW-1:0]  res1,
    output logic           zero0,
    output logic           zero1,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_c,
    input  logic           alu_zero,
    output logic           busy
);

    localparam logic [OPW-1:0] ALU_NOP = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic           owner_reg, owner_next;
    logic           last_reg, last_next;
    logic [OPW-1:0] op_reg, op_next;
    logic [DW-1:0]  a_reg, a_next;
    logic [DW-1:0]  b_reg, b_next;

    // Requester inputs gathered into vectors, indexed by requester id.
    logic [1:0][OPW-1:0] op_vec;
    logic [1:0][DW-1:0]  a_vec;
    logic [1:0][DW-1:0]  b_vec;
    logic [1:0][DW-1:0]  res_vec;
    logic [1:0]          zero_vec;
    logic [1:0]          done_vec;

    assign op_vec = {op1, op0};
    assign a_vec  = {a1, a0};
    assign b_vec  = {b1, b0};

    // Round-robin pick: a lone request wins outright. On a tie, the
    // requester that was not granted last time wins.
    logic grant_valid;
    logic grant_id;

    assign grant_valid = req0 | req1;
    assign grant_id    = (req0 & req1) ? ~last_reg : req1;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
        end
    end

    // Next-state and ALU drive
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        alu_op     = ALU_NOP;
        alu_a      = '0;
        alu_b      = '0;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = EXEC;
                    owner_next = grant_id;
                    last_next  = grant_id;
                    op_next    = op_vec[grant_id];
                    a_next     = a_vec[grant_id];
                    b_next     = b_vec[grant_id];
                end
            end
            EXEC: begin
                // Only the latched copy reaches the ALU, so inputs may
                // change freely while the operation is in flight.
                alu_op     = op_reg;
                alu_a      = a_reg;
                alu_b      = b_reg;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Per-requester result/zero registers and done decode. The capture
    // happens on the EXEC->DONE edge, while the ALU still sees the latched
    // operands.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic [DW-1:0] res_reg;
        logic          zero_reg;
        logic          mine;

        assign mine = (owner_reg == 1'(gi));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                res_reg  <= '0;
                zero_reg <= 1'b0;
            end else if (state_reg == EXEC && mine) begin
                res_reg  <= alu_c;
                zero_reg <= alu_zero;
            end
        end

        assign res_vec[gi]  = res_reg;
        assign zero_vec[gi] = zero_reg;
        assign done_vec[gi] = (state_reg == DONE) && mine;
    end

    assign res0  = res_vec[0];
    assign res1  = res_vec[1];
    assign zero0 = zero_vec[0];
    assign zero1 = zero_vec[1];
    assign done0 = done_vec[0];
    assign done1 = done_vec[1];

endmodule

// File: tb/tb_alu_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_arb -- self-checking bench for alu_arb.
//
// The bench provides its own shared ALU. A transaction-level model runs beside
// the DUT. Each grant occupies a three-edge slot. The result appears one edge
// after the grant. The model's result comes from the operands present at the
// grant edge. A compare process checks every DUT output on every falling edge.
// Directed scenarios add literal expectations. A long randomized run follows,
// with random operand churn and occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_alu_arb;

    localparam int DW  = 32;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_NOP  = 4'd0;
    localparam logic [OPW-1:0] OP_ADD  = 4'd1;
    localparam logic [OPW-1:0] OP_SUB  = 4'd2;
    localparam logic [OPW-1:0] OP_AND  = 4'd3;
    localparam logic [OPW-1:0] OP_OR   = 4'd4;
    localparam logic [OPW-1:0] OP_XOR  = 4'd5;
    localparam logic [OPW-1:0] OP_SLT  = 4'd6;
    localparam logic [OPW-1:0] OP_SLTU = 4'd7;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [OPW-1:0] op0 = '0, op1 = '0;
    logic [DW-1:0]  a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic           done0, done1, zero0, zero1, busy;
    logic [DW-1:0]  res0, res1, alu_a, alu_b, alu_c;
    logic [OPW-1:0] alu_op;
    logic           alu_zero;

    always #5 clk = ~clk;

    alu_arb #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .done0(done0), .done1(done1),
        .res0(res0), .res1(res1),
        .zero0(zero0), .zero1(zero1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Shared ALU
    function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(DW-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    assign alu_c    = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_c == '0);

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int             edge_cnt = 0;
    int             grant_at = -100;
    logic           m_owner  = 1'b0;
    logic           m_last   = 1'b1;
    logic [OPW-1:0] m_op     = '0;
    logic [DW-1:0]  m_a      = '0;
    logic [DW-1:0]  m_b      = '0;
    logic [DW-1:0]  m_pend   = '0;
    logic [DW-1:0]  m_res [2] = '{default: '0};
    logic           m_zero[2] = '{default: 1'b0};

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            grant_at  = -100;
            m_owner   = 1'b0;
            m_last    = 1'b1;
            m_op      = '0;
            m_a       = '0;
            m_b       = '0;
            m_res[0]  = '0;
            m_res[1]  = '0;
            m_zero[0] = 1'b0;
            m_zero[1] = 1'b0;
        end else begin
            // Post the pending result one edge after its grant.
            if (edge_cnt - grant_at == 1) begin
                m_res[m_owner]  = m_pend;
                m_zero[m_owner] = (m_pend == '0);
            end
            // A slot lasts three edges. A request is honoured only once the previous slot is over.
            if (edge_cnt - grant_at >= 3 && (req0 || req1)) begin
                m_owner  = (req0 && req1) ? ~m_last : req1;
                m_last   = m_owner;
                m_op     = m_owner ? op1 : op0;
                m_a      = m_owner ? a1 : a0;
                m_b      = m_owner ? b1 : b0;
                m_pend   = alu_f(m_op, m_a, m_b);
                grant_at = edge_cnt;
            end
            edge_cnt = edge_cnt + 1;
        end
    end

    // Compare process: every output, every cycle.
    initial forever begin
        int   age;
        logic in_exec, in_done;
        @(negedge clk);
        age     = edge_cnt - 1 - grant_at;
        in_exec = (age == 0);
        in_done = (age == 1);
        check("busy",   32'(busy),   32'(in_exec | in_done));
        check("done0",  32'(done0),  32'(in_done & ~m_owner));
        check("done1",  32'(done1),  32'(in_done & m_owner));
        check("res0",   res0,        m_res[0]);
        check("res1",   res1,        m_res[1]);
        check("zero0",  32'(zero0),  32'(m_zero[0]));
        check("zero1",  32'(zero1),  32'(m_zero[1]));
        check("alu_op", 32'(alu_op), in_exec ? 32'(m_op) : 32'(OP_NOP));
        check("alu_a",  alu_a,       in_exec ? m_a : '0);
        check("alu_b",  alu_b,       in_exec ? m_b : '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #2;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done0",  32'(done0),  32'd0);
        check("rst_res0",   res0,        32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        tick();
        tick();
        rstn = 1'b1;

        // Idle bus
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_alu_op", 32'(alu_op), 32'd0);
            check("idle_alu_a",  alu_a,       32'd0);
            check("idle_busy",   32'(busy),   32'd0);
        end

        // Lone request: 5 + 7
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7;
        tick();
        check("lone_busy",  32'(busy),  32'd1);
        check("lone_done0_early", 32'(done0), 32'd0);
        req0 = 1'b0; a0 = 32'd100;
        tick();
        check("lone_done0", 32'(done0), 32'd1);
        check("lone_res0",  res0,       32'd12);
        check("lone_zero0", 32'(zero0), 32'd0);
        check("lone_res1",  res1,       32'd0);
        check("model_res0", m_res[0],   32'd12);
        tick();
        check("lone_done0_end", 32'(done0), 32'd0);
        check("lone_hold0",     res0,       32'd12);

        // Operand stability: 9 - 9 with a1 changed during EXEC
        req1 = 1'b1; op1 = OP_SUB; a1 = 32'd9; b1 = 32'd9;
        tick();
        a1 = 32'd3; req1 = 1'b0;
        check("stab_alu_a", alu_a, 32'd9);
        tick();
        check("stab_done1", 32'(done1), 32'd1);
        check("stab_res1",  res1,       32'd0);
        check("stab_zero1", 32'(zero1), 32'd1);
        check("stab_res0",  res0,       32'd12);
        tick();

        // Signed versus unsigned compare
        req0 = 1'b1; op0 = OP_SLT; a0 = 32'hFFFF_FFFF; b0 = 32'd1;
        tick();
        req0 = 1'b0;
        tick();
        check("slt_res0", res0, 32'd1);
        tick();
        req0 = 1'b1; op0 = OP_SLTU;
        tick();
        req0 = 1'b0;
        tick();
        check("sltu_res0",  res0,       32'd0);
        check("sltu_zero0", 32'(zero0), 32'd1);
        tick();

        // Tie after reset: grant order 0,1,0
        #2 rstn = 1'b0;
        #1 check("tie_rst_res1", res1, 32'd0);
        tick();
        rstn = 1'b1;
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd1; b0 = 32'd1;
        req1 = 1'b1; op1 = OP_ADD; a1 = 32'd2; b1 = 32'd3;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("tie_done0_%0d", k), 32'(done0), 32'((k == 1) || (k == 7)));
            check($sformatf("tie_done1_%0d", k), 32'(done1), 32'(k == 4));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        check("tie_res1", res1, 32'd5);

        // Reset during EXEC
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd20; b0 = 32'd22;
        tick();
        #2 rstn = 1'b0;
        #1;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done0", 32'(done0), 32'd0);
        check("abort_res0",  res0,       32'd0);
        check("abort_res1",  res1,       32'd0);
        tick();
        check("abort_done0_hold", 32'(done0), 32'd0);
        rstn = 1'b1;
        tick();
        check("post_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        tick();
        check("post_done0", 32'(done0), 32'd1);
        check("post_res0",  res0,       32'd42);
        tick();

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            tick();
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            op0  = OPW'($urandom_range(0, 8));
            op1  = OPW'($urandom_range(0, 8));
            a0   = $urandom;
            a1   = $urandom;
            b0   = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1   = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            if (!rstn) begin
                #2 rstn = 1'b1;
            end else if ($urandom_range(0, 49) == 0) begin
                #2 rstn = 1'b0;
            end
        end
        rstn = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
